// File: rtl/sprite_loader.sv
// sprite_loader -- writer side of the 64x64 sprite texture memory.
//
// Takes a valid/ready byte stream and fills a 4096-word sprite RAM in the
// renderer's scan order: address = {col,row}, row (low 6 bits) advancing
// first. The renderer reads through an asynchronous col/row -> val port.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      synchronous active-high reset (RAM contents are kept)
//   start      one-cycle pulse, (re)starts a load at address 0
//   in_data    stream byte, low CHANNEL_BITS*3 bits stored
//   in_valid   in_data valid this cycle
//   in_ready   loader accepts a byte this cycle (high only while loading)
//   busy       load in progress
//   done       full load completed, held until next start or reset
//   load_addr  next write address {col,row}
//   col, row   renderer read address
//   val        data[{col,row}], combinational
module sprite_loader #(
  parameter int CHANNEL_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      done,
  output logic [11:0]               load_addr,
  input  logic [5:0]                col,
  input  logic [5:0]                row,
  output logic [CHANNEL_BITS*3-1:0] val
);
  localparam int W = CHANNEL_BITS * 3;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t       state, state_nxt;
  logic         we;
  logic [W-1:0] mem [4096];

  // Upper stream bits carry no data for this word width.
  logic unused_bits;
  assign unused_bits = ^in_data[7:W];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        // start wins over a coincident transfer; reset blocks the write so
        // an abandoned load leaves the current address untouched.
        we = in_valid && !start && !reset;
        if (!start && we && load_addr == 12'hfff) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wraps to 0 naturally after the final word.
  always_ff @(posedge clk) begin
    if (reset)      load_addr <= '0;
    else if (start) load_addr <= '0;
    else if (we)    load_addr <= load_addr + 12'd1;
  end

  // Array has no reset: contents survive reset and abandoned loads.
  always_ff @(posedge clk) begin
    if (we) mem[load_addr] <= in_data[W-1:0];
  end

  assign val = mem[{col, row}];

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Writer side of the 64x64 sprite texture memory.
- Accepts a byte stream with a valid/ready handshake and fills a 4096-entry sprite RAM in the same scan order the renderer uses (Y first, then X, address = {col,row}).
- Exposes the same combinational col/row -> val read port the renderer already consumes, so sprite data is loadable at runtime and no longer depends on a sim-time file preload.
- Sits between the host/SPI byte deframer and the sprite pixel path.

Parameters:
- CHANNEL_BITS, 2, bits per colour channel; stored and read word width is CHANNEL_BITS*3.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new 4096-word load at address 0.
- in_data  input  8  stream byte; bits [CHANNEL_BITS*3-1:0] are stored, upper bits ignored.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- busy  output  1  high while a load is in progress.
- done  output  1  high after a complete load; held until next start or reset.
- load_addr  output  12  next write address {col,row}, for debug/status.
- col  input  6  renderer read column.
- row  input  6  renderer read row.
- val  output  CHANNEL_BITS*3  data[{col,row}], combinational from the array.

Behaviour:
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, load_addr=0.
- Reset does NOT clear RAM contents. Reset mid-load abandons the load; words already written remain.
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0. start -> LOAD, load_addr<=0.
- LOAD:
  - busy=1, in_ready=1 (combinational from state).
  - A transfer occurs when in_valid && in_ready. On a transfer: data[load_addr] <= in_data[CHANNEL_BITS*3-1:0], then load_addr <= load_addr+1.
  - in_valid low inserts wait cycles; no write, address unchanged.
  - Transfer at load_addr==4095: write occurs, load_addr wraps to 0, next state DONE.
- DONE: done=1, busy=0, in_ready=0. Bytes presented in IDLE/DONE are not accepted and not written.
- start while in LOAD: restarts at address 0, stays in LOAD. Any transfer in that same cycle is discarded (start has priority).
- start while in DONE or IDLE: done<=0, go to LOAD.
- Address order: load_addr[5:0] is row and increments first; load_addr[11:6] is col. Byte n lands at col=n/64, row=n%64.
- Read port:
  - Purely combinational, independent of loader state.
  - A write takes effect for reads from the cycle after the write edge.
  - Reading the address being written in the same cycle returns the old value.
- Memory is a single write port and a single asynchronous read port. No other ports on the array.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> in_ready=0, busy=0, done=0, load_addr=0, no RAM write.
- Full load: start, then 4096 back-to-back bytes with value n&63 -> done=1 one cycle after byte 4095.
  - Read checks: col=1,row=0 -> val=0 (n=64); col=0,row=5 -> 5; col=63,row=63 -> 63.
- Throttling: toggle in_valid randomly during a load with bytes 8'hC0|k -> upper bits dropped; val==k&63 at each address.
  - load_addr advances only on transfer cycles; busy stays 1 throughout.
- Overrun: after done, hold in_valid=1 with 8'h3F for 10 cycles -> in_ready=0, address 0 keeps its loaded value.
- Restart: start mid-load at load_addr=100 with in_valid=1 -> that byte is discarded, load_addr=0, next byte is written to address 0.
  - done only after 4096 further transfers.
- Reset mid-load at load_addr=2000: state=IDLE, load_addr=0, done=0.
  - Addresses 0..1999 retain their new data; address 2000 retains its prior data.
